// File: rtl/sme_pkg.sv
// Shared types and constants for the string-match scan sequencer.
package sme_pkg;

    localparam int unsigned STR_MAX  = 32;
    localparam int unsigned PAT_MAX  = 8;
    localparam int unsigned WDOG_CYC = 15;

    localparam int unsigned STR_AW = 5;
    localparam int unsigned PAT_AW = 3;
    localparam int unsigned SLEN_W = 6;
    localparam int unsigned PLEN_W = 4;

    // Pattern metacharacters interpreted by the compare datapath.
    localparam logic [7:0] CHAR_DOT  = 8'h2E;
    localparam logic [7:0] CHAR_STAR = 8'h2A;
    localparam logic [7:0] CHAR_HEAD = 8'h5E;
    localparam logic [7:0] CHAR_TAIL = 8'h24;

    typedef enum logic [2:0] {
        StIdle,
        StLdStr,
        StLdPat,
        StCheck,
        StIssue,
        StWait,
        StReport
    } state_e;

endpackage

// File: rtl/sme_len_cnt.sv
// Saturating length counter; flags whether the current char is actually stored.
module sme_len_cnt #(
    parameter int unsigned Max  = 32,
    parameter int unsigned LenW = 6
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [LenW-1:0] len_o,
    output logic            we_o
);

    localparam logic [LenW-1:0] MaxLen = LenW'(Max);

    logic [LenW-1:0] len_d, len_q;

    // clr restarts the count; with inc the char goes to slot 0 and length becomes 1.
    always_comb begin
        len_d = len_q;
        we_o  = 1'b0;
        if (clr_i) begin
            len_d = inc_i ? LenW'(1) : '0;
            we_o  = inc_i;
        end else if (inc_i && (len_q < MaxLen)) begin
            len_d = len_q + LenW'(1);
            we_o  = 1'b1;
        end
    end

    // Length register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end

    assign len_o = len_q;

endmodule

// File: rtl/sme_scan_sched.sv
// Scan sequencer: loads string/pattern, steps compare windows, reports first hit.
// Optional compare-response watchdog enabled by defining SME_WDOG_EN.
module sme_scan_sched
    import sme_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        chardata_i,
    input  logic              isstring_i,
    input  logic              ispattern_i,
    output logic              str_we_o,
    output logic [STR_AW-1:0] str_addr_o,
    output logic              pat_we_o,
    output logic [PAT_AW-1:0] pat_addr_o,
    output logic [7:0]        wr_data_o,
    output logic [SLEN_W-1:0] slen_o,
    output logic [PLEN_W-1:0] plen_o,
    output logic              cmp_start_o,
    output logic [STR_AW-1:0] cmp_pos_o,
    input  logic              cmp_done_i,
    input  logic              cmp_hit_i,
    output logic              valid_o,
    output logic              match_o,
    output logic [STR_AW-1:0] match_index_o
`ifdef SME_WDOG_EN
    ,
    output logic              wdog_flag_o
`endif
);

    state_e              state_q;
    logic [STR_AW-1:0]   pos_q;
    logic                cmp_start_q, valid_q, match_q;
    logic [STR_AW-1:0]   idx_q;
    logic                str_we_q, pat_we_q;
    logic [STR_AW-1:0]   str_addr_q;
    logic [PAT_AW-1:0]   pat_addr_q;
    logic [7:0]          wr_data_q;

    logic                str_inc, str_clr, str_we;
    logic                pat_inc, pat_clr, pat_we;
    logic [SLEN_W-1:0]   slen, plen_ext, last;
    logic [PLEN_W-1:0]   plen;
    logic                no_scan;

`ifdef SME_WDOG_EN
    localparam logic [3:0] WdogLast = 4'(WDOG_CYC - 1);
    logic [3:0] wdog_cnt_q;
    logic       wdog_flag_q;
`endif

    sme_len_cnt #(.Max(STR_MAX), .LenW(SLEN_W)) u_str_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (str_clr),
        .inc_i  (str_inc),
        .len_o  (slen),
        .we_o   (str_we)
    );

    sme_len_cnt #(.Max(PAT_MAX), .LenW(PLEN_W)) u_pat_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (pat_clr),
        .inc_i  (pat_inc),
        .len_o  (plen),
        .we_o   (pat_we)
    );

    // Load-side counter control; chars outside the load states are dropped.
    always_comb begin
        str_inc = 1'b0;
        str_clr = 1'b0;
        pat_inc = 1'b0;
        pat_clr = 1'b0;
        if (state_q inside {StIdle, StLdStr, StLdPat}) begin
            if (isstring_i) begin
                str_inc = 1'b1;
                str_clr = (state_q != StLdStr);
                // A new string arriving mid-pattern discards that pattern.
                pat_clr = (state_q == StLdPat);
            end else if (ispattern_i) begin
                pat_inc = 1'b1;
                pat_clr = (state_q != StLdPat);
            end
        end
    end

    assign plen_ext = {{(SLEN_W - PLEN_W){1'b0}}, plen};
    assign no_scan  = (slen == '0) || (plen == '0) || (plen_ext > slen);
    // Only consulted after CHECK has ruled out plen > slen.
    assign last     = slen - plen_ext;

    // Main FSM with registered write-port and result outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            pos_q       <= '0;
            cmp_start_q <= 1'b0;
            valid_q     <= 1'b0;
            match_q     <= 1'b0;
            idx_q       <= '0;
            str_we_q    <= 1'b0;
            str_addr_q  <= '0;
            pat_we_q    <= 1'b0;
            pat_addr_q  <= '0;
            wr_data_q   <= '0;
`ifdef SME_WDOG_EN
            wdog_cnt_q  <= '0;
            wdog_flag_q <= 1'b0;
`endif
        end else begin
            cmp_start_q <= 1'b0;
            valid_q     <= 1'b0;
            match_q     <= 1'b0;
            idx_q       <= '0;
            str_we_q    <= str_we;
            pat_we_q    <= pat_we;
            if (str_we) str_addr_q <= str_clr ? '0 : slen[STR_AW-1:0];
            if (pat_we) pat_addr_q <= pat_clr ? '0 : plen[PAT_AW-1:0];
            if (str_inc || pat_inc) wr_data_q <= chardata_i;

            unique case (state_q)
                StIdle: begin
                    if (isstring_i)       state_q <= StLdStr;
                    else if (ispattern_i) state_q <= StLdPat;
                end
                StLdStr: begin
                    if (!isstring_i) state_q <= ispattern_i ? StLdPat : StIdle;
                end
                StLdPat: begin
                    if (isstring_i)        state_q <= StLdStr;
                    else if (!ispattern_i) state_q <= StCheck;
                end
                StCheck: begin
                    if (no_scan) begin
                        state_q <= StReport;
                        valid_q <= 1'b1;
                    end else begin
                        pos_q       <= '0;
                        state_q     <= StIssue;
                        cmp_start_q <= 1'b1;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
`ifdef SME_WDOG_EN
                    wdog_cnt_q <= 4'd1;
`endif
                end
                StWait: begin
                    if (cmp_done_i) begin
                        if (cmp_hit_i) begin
                            state_q <= StReport;
                            valid_q <= 1'b1;
                            match_q <= 1'b1;
                            idx_q   <= pos_q;
                        end else if ({1'b0, pos_q} == last) begin
                            state_q <= StReport;
                            valid_q <= 1'b1;
                        end else begin
                            pos_q       <= pos_q + 5'd1;
                            state_q     <= StIssue;
                            cmp_start_q <= 1'b1;
                        end
                    end
`ifdef SME_WDOG_EN
                    else if (wdog_cnt_q == WdogLast) begin
                        state_q     <= StReport;
                        valid_q     <= 1'b1;
                        wdog_flag_q <= 1'b1;
                    end else begin
                        wdog_cnt_q <= wdog_cnt_q + 4'd1;
                    end
`endif
                end
                StReport: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

    assign str_we_o      = str_we_q;
    assign str_addr_o    = str_addr_q;
    assign pat_we_o      = pat_we_q;
    assign pat_addr_o    = pat_addr_q;
    assign wr_data_o     = wr_data_q;
    assign slen_o        = slen;
    assign plen_o        = plen;
    assign cmp_start_o   = cmp_start_q;
    assign cmp_pos_o     = pos_q;
    assign valid_o       = valid_q;
    assign match_o       = match_q;
    assign match_index_o = idx_q;
`ifdef SME_WDOG_EN
    assign wdog_flag_o   = wdog_flag_q;
`endif

endmodule

// File: tb/tb_sme_scan_sched.sv
// Self-checking bench for sme_scan_sched: vector table plus reset/long-string/watchdog sequences.
module tb_sme_scan_sched;
    import sme_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] chardata = '0;
    logic       isstring = 1'b0, ispattern = 1'b0;
    logic       str_we, pat_we, cmp_start, valid, match;
    logic [4:0] str_addr, cmp_pos, match_index;
    logic [2:0] pat_addr;
    logic [7:0] wr_data;
    logic [5:0] slen;
    logic [3:0] plen;
    logic       cmp_done, cmp_hit;
    logic       resp_done = 1'b0, resp_hit = 1'b0, man_done = 1'b0, man_hit = 1'b0;
`ifdef SME_WDOG_EN
    logic       wdog_flag;
`endif

    assign cmp_done = resp_done | man_done;
    assign cmp_hit  = resp_hit | man_hit;

    always #5 clk = ~clk;

    sme_scan_sched dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .chardata_i    (chardata),
        .isstring_i    (isstring),
        .ispattern_i   (ispattern),
        .str_we_o      (str_we),
        .str_addr_o    (str_addr),
        .pat_we_o      (pat_we),
        .pat_addr_o    (pat_addr),
        .wr_data_o     (wr_data),
        .slen_o        (slen),
        .plen_o        (plen),
        .cmp_start_o   (cmp_start),
        .cmp_pos_o     (cmp_pos),
        .cmp_done_i    (cmp_done),
        .cmp_hit_i     (cmp_hit),
        .valid_o       (valid),
        .match_o       (match),
        .match_index_o (match_index)
`ifdef SME_WDOG_EN
        ,
        .wdog_flag_o   (wdog_flag)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected compare positions and expected results.
    typedef struct packed {
        logic       m;
        logic [4:0] idx;
    } res_t;
    logic [4:0] exp_pos_q[$];
    res_t       exp_res_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmp_start) begin
                if (exp_pos_q.size() == 0) check("unexpected_cmp_start", 64'(1), 64'(0));
                else check("cmp_pos", 64'(cmp_pos), 64'(exp_pos_q.pop_front()));
            end
            if (valid) begin
                if (exp_res_q.size() == 0) begin
                    check("unexpected_valid", 64'(1), 64'(0));
                end else begin
                    res_t r;
                    r = exp_res_q.pop_front();
                    check("result", 64'({match, match_index}), 64'({r.m, r.idx}));
                end
            end else begin
                check("result_idle", 64'({match, match_index}), 64'(0));
            end
        end
    end

    // Compare-datapath model: answers each request one cycle after it, hitting at hit_pos.
    int   hit_pos = -1;
    int   resp_left = 0;
    logic pend = 1'b0, pend_hit = 1'b0;
    always @(posedge clk) begin
        #1;
        resp_done = pend;
        resp_hit  = pend & pend_hit;
        pend      = 1'b0;
        if (rst_n && cmp_start && resp_left > 0) begin
            pend     = 1'b1;
            pend_hit = (int'(cmp_pos) == hit_pos);
            resp_left--;
        end
    end

    typedef struct packed {
        logic         load_str;
        logic [127:0] str;
        int           slen;
        logic [127:0] pat;
        int           plen;
        int           hit;
        logic         m;
        int           idx;
    } vec_t;

    function automatic vec_t mk(input logic ld, input logic [127:0] s, input int sl,
                                input logic [127:0] p, input int pl, input int h,
                                input logic m, input int idx);
        vec_t v;
        v.load_str = ld; v.str = s; v.slen = sl; v.pat = p; v.plen = pl;
        v.hit = h; v.m = m; v.idx = idx;
        return v;
    endfunction

    int cur_slen = 0;

    // Waits for the result strobe; returns cycles from pattern fall, or -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) check("valid_timeout", 64'(0), 64'(1));
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        int   plen_e, last, n_iss, lat;
        logic noscan;
        hit_pos   = v.hit;
        resp_left = 1000;
        if (v.load_str) begin
            for (int i = 0; i < v.slen; i++) begin
                isstring = 1'b1;
                chardata = v.str[8*(v.slen-1-i) +: 8];
                tick();
                check("str_write", 64'({str_we, str_addr, wr_data}), 64'({1'b1, 5'(i), chardata}));
            end
            isstring = 1'b0;
            cur_slen = v.slen;
        end
        for (int i = 0; i < v.plen; i++) begin
            ispattern = 1'b1;
            chardata  = v.pat[8*(v.plen-1-i) +: 8];
            tick();
            if (i < 8) check("pat_write", 64'({pat_we, pat_addr, wr_data}), 64'({1'b1, 3'(i), chardata}));
            else       check("pat_drop", 64'(pat_we), 64'(0));
        end
        plen_e = (v.plen > 8) ? 8 : v.plen;
        check("slen", 64'(slen), 64'(cur_slen));
        check("plen", 64'(plen), 64'(plen_e));
        noscan = (cur_slen == 0) || (plen_e == 0) || (plen_e > cur_slen);
        last   = cur_slen - plen_e;
        if (noscan)                               n_iss = 0;
        else if (v.hit >= 0 && v.hit <= last)     n_iss = v.hit + 1;
        else                                      n_iss = last + 1;
        for (int p = 0; p < n_iss; p++) exp_pos_q.push_back(5'(p));
        exp_res_q.push_back('{m: v.m, idx: 5'(v.idx)});
        ispattern = 1'b0;
        wait_valid(lat);
        if (noscan) check("noscan_latency", 64'(lat), 64'(2));
        check("queues_drained", 64'(exp_pos_q.size() + exp_res_q.size()), 64'(0));
    endtask

    vec_t vecs[8];

    initial begin
        int lat;
        vecs[0] = mk(1'b1, "ABCDE",    5, "CD",         2,  2, 1'b1, 2);
        vecs[1] = mk(1'b0, "",         0, "E",          1,  4, 1'b1, 4);
        vecs[2] = mk(1'b1, "ABC",      3, "XY",         2, -1, 1'b0, 0);
        vecs[3] = mk(1'b1, "AB",       2, "ABC",        3, -1, 1'b0, 0);
        vecs[4] = mk(1'b1, "ABCDEFGH", 8, "H",          1,  7, 1'b1, 7);
        vecs[5] = mk(1'b1, "ABCD",     4, "ABCD",       4,  0, 1'b1, 0);
        vecs[6] = mk(1'b1, "ABCDEF",   6, "ABCDEFGHIJ", 10, -1, 1'b0, 0);
        vecs[7] = mk(1'b1, "XYZ",      3, "Q",          1,  5, 1'b0, 0);

        // Reset values.
        #12;
        check("reset_outputs", 64'({str_we, str_addr, pat_we, pat_addr, wr_data, slen, plen,
                                    cmp_start, cmp_pos, valid, match, match_index}), 64'(0));
        check("reset_state", 64'(dut.state_q), 64'(StIdle));
        rst_n = 1'b1;
        tick();

        // Reset mid-WAIT at pos 3: three misses, then the model goes silent.
        hit_pos   = -1;
        resp_left = 3;
        for (int i = 0; i < 8; i++) begin
            isstring = 1'b1; chardata = 8'h41 + 8'(i); tick();
        end
        isstring = 1'b0; ispattern = 1'b1; chardata = "Z"; tick();
        ispattern = 1'b0;
        for (int p = 0; p < 4; p++) exp_pos_q.push_back(5'(p));
        for (int c = 0; c < 100 && exp_pos_q.size() != 0; c++) tick();
        check("midwait_issued", 64'(exp_pos_q.size()), 64'(0));
        tick(); tick();
        check("midwait_pos", 64'(cmp_pos), 64'(3));
        #2 rst_n = 1'b0;
        #1;
        check("midscan_reset_outputs", 64'({str_we, str_addr, pat_we, pat_addr, wr_data, slen, plen,
                                            cmp_start, cmp_pos, valid, match, match_index}), 64'(0));
        check("midscan_reset_state", 64'(dut.state_q), 64'(StIdle));
        #2 rst_n = 1'b1;
        exp_pos_q.delete();
        exp_res_q.delete();
        cur_slen = 0;
        tick();
        man_done = 1'b1; man_hit = 1'b1;
        tick();
        man_done = 1'b0; man_hit = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("stale_done_no_valid", 64'(valid), 64'(0));
            tick();
        end

        // Table-driven scans.
        foreach (vecs[k]) run_vec(vecs[k]);

        // 34-char string: writes beyond 32 dropped; both strobes high favours the string.
        hit_pos   = -1;
        resp_left = 1000;
        for (int i = 0; i < 34; i++) begin
            isstring  = 1'b1;
            ispattern = (i == 5);
            chardata  = 8'h61 + 8'(i % 26);
            tick();
            if (i < 32) check("long_str_write", 64'({str_we, str_addr}), 64'({1'b1, 5'(i)}));
            else        check("long_str_drop", 64'(str_we), 64'(0));
            if (i == 5) check("precedence_no_pat_we", 64'(pat_we), 64'(0));
        end
        isstring = 1'b0; ispattern = 1'b1; chardata = "A"; tick();
        check("long_slen", 64'(slen), 64'(32));
        check("long_plen", 64'(plen), 64'(1));
        for (int p = 0; p < 32; p++) exp_pos_q.push_back(5'(p));
        exp_res_q.push_back('{m: 1'b0, idx: 5'd0});
        ispattern = 1'b0;
        tick(); tick(); tick();
        // A string char during the scan must be ignored.
        isstring = 1'b1; chardata = "Z"; tick();
        isstring = 1'b0;
        check("scan_char_dropped", 64'(str_we), 64'(0));
        wait_valid(lat);
        check("long_queues_drained", 64'(exp_pos_q.size() + exp_res_q.size()), 64'(0));
        check("long_slen_kept", 64'(slen), 64'(32));

`ifdef SME_WDOG_EN
        // Watchdog: no response ever; timeout result 15 cycles after the request.
        begin
            int t_start, t_valid, t;
            resp_left = 0;
            t_start = -1; t_valid = -1; t = 0;
            for (int i = 0; i < 3; i++) begin
                isstring = 1'b1; chardata = 8'h41 + 8'(i); tick();
            end
            isstring = 1'b0; ispattern = 1'b1; chardata = "A"; tick();
            ispattern = 1'b0;
            exp_pos_q.push_back(5'd0);
            exp_res_q.push_back('{m: 1'b0, idx: 5'd0});
            check("wdog_flag_clear", 64'(wdog_flag), 64'(0));
            for (int c = 0; c < 60 && t_valid < 0; c++) begin
                tick();
                t++;
                if (cmp_start && t_start < 0) t_start = t;
                if (valid) t_valid = t;
            end
            tick();
            check("wdog_latency", 64'(t_valid - t_start), 64'(15));
            check("wdog_flag_set", 64'(wdog_flag), 64'(1));
            tick(); tick();
            check("wdog_flag_sticky", 64'(wdog_flag), 64'(1));
            #2 rst_n = 1'b0;
            #1;
            check("wdog_flag_reset", 64'(wdog_flag), 64'(0));
            #2 rst_n = 1'b1;
            tick();
        end
`endif

        check("final_queues_empty", 64'(exp_pos_q.size() + exp_res_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
